// File: rtl/io_periph_if.sv
// io_periph_if: CPU-side IO bus bundle for io_periph.
// The master (CPU side) drives the strobes, the address and the write data.
// The slave (peripheral) returns the read data.
interface io_periph_if;
    logic        LEDCtrl;
    logic        SwitchCtrl;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [15:0] io_rdata;

    modport master (
        output LEDCtrl,
        output SwitchCtrl,
        output addr,
        output write_data,
        input  io_rdata
    );

    modport slave (
        input  LEDCtrl,
        input  SwitchCtrl,
        input  addr,
        input  write_data,
        output io_rdata
    );
endinterface

// File: rtl/io_periph.sv
// io_periph: memory-mapped LED register and debounced switch port.
// - A write strobe on LED_ADDR loads the 16-bit LED register.
// - The raw switches pass through a two-flop synchroniser.
// - A debouncer then requires DEBOUNCE_CYCLES stable clocks before it
//   accepts a change.
// - A sticky change flag records accepted changes. A status read clears it.
// Optional build macro IO_LED_READBACK_EN: when it is defined, a read
// strobe on LED_ADDR returns the LED register. When it is not defined,
// that read returns zero and no readback mux is built.
module io_periph #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] LED_ADDR        = 32'hFFFFFC60,
    parameter logic [31:0] SW_ADDR         = 32'hFFFFFC70,
    parameter logic [31:0] STAT_ADDR       = 32'hFFFFFC72
) (
    input  logic          clock,
    input  logic          rst_n,
    io_periph_if.slave    bus,
    input  logic [15:0]   switch_in,
    output logic [15:0]   led_out
);

    // The counter is 20 bits wide. It stops at its terminal value, so it never wraps.
    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    logic [15:0] led_q,    led_d;
    logic [15:0] sync1_q,  sync1_d;
    logic [15:0] sync2_q,  sync2_d;
    logic [15:0] cand_q,   cand_d;
    logic [15:0] sw_q,     sw_d;
    logic [19:0] cnt_q,    cnt_d;
    logic        chg_q,    chg_d;

    // Store data bits 31:16 have no destination. They are collected here so they are visibly unused.
    logic        unused_wdata_hi;
    assign unused_wdata_hi = ^bus.write_data[31:16];

    // Next-state logic for the LED register, the synchroniser, the debouncer and the change flag
    always_comb begin
        led_d   = led_q;
        sync1_d = switch_in;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        chg_d   = chg_q;

        if (bus.LEDCtrl && (bus.addr == LED_ADDR)) begin
            led_d = bus.write_data[15:0];
        end

        // Any difference from the candidate restarts the stability count.
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 20'd1;
        end

        // The candidate has been held long enough, so accept it.
        if (cnt_q == CNT_MAX) begin
            sw_d = cand_q;
        end

        // The clear is applied first, so a set on the same edge takes priority.
        if (bus.SwitchCtrl && (bus.addr == STAT_ADDR)) begin
            chg_d = 1'b0;
        end
        if (sw_d != sw_q) begin
            chg_d = 1'b1;
        end
    end

    // State registers. Reset is asynchronous and active low.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            sw_q    <= '0;
            chg_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            chg_q   <= chg_d;
        end
    end

    // Same-cycle read mux. It sees only registered state, never the raw switches.
    always_comb begin
        bus.io_rdata = 16'h0000;
        if (bus.SwitchCtrl) begin
            if (bus.addr == SW_ADDR) begin
                bus.io_rdata = sw_q;
            end else if (bus.addr == STAT_ADDR) begin
                bus.io_rdata = {15'b0, chg_q};
            end
`ifdef IO_LED_READBACK_EN
            else if (bus.addr == LED_ADDR) begin
                bus.io_rdata = led_q;
            end
`endif
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_io_periph.sv
// tb_io_periph: directed test of io_periph with DEBOUNCE_CYCLES = 4.
// With 4 stable cycles required, an accepted switch change shows up 7 edges
// after the first edge that samples it.
`timescale 1ns/1ps
module tb_io_periph;

    localparam logic [31:0] LED_A  = 32'hFFFFFC60;
    localparam logic [31:0] SW_A   = 32'hFFFFFC70;
    localparam logic [31:0] STAT_A = 32'hFFFFFC72;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic [15:0] rb_exp;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    io_periph_if bus_if ();

    io_periph #(
        .DEBOUNCE_CYCLES (4),
        .LED_ADDR        (LED_A),
        .SW_ADDR         (SW_A),
        .STAT_ADDR       (STAT_A)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .switch_in (switch_in),
        .led_out   (led_out)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("check %-14s got %h expected %h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-14s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge. Inputs and sample points sit 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [31:0] a, output logic [15:0] d);
        bus_if.SwitchCtrl = 1'b1;
        bus_if.addr       = a;
        #1;
        d = bus_if.io_rdata;
    endtask

    logic [15:0] r;

    initial begin
        rst_n                = 1'b0;
        switch_in            = 16'h0000;
        bus_if.LEDCtrl       = 1'b0;
        bus_if.SwitchCtrl    = 1'b1;
        bus_if.addr          = SW_A;
        bus_if.write_data    = 32'h0;
        #3;
        check_eq("rst_led", 32'(led_out), 32'h0);
        check_eq("rst_rdata", 32'(bus_if.io_rdata), 32'h0);
        #4 rst_n = 1'b1;
        ticks(6);

        // LED write to the LED address, then the same write to a neighbouring address
        bus_if.LEDCtrl    = 1'b1;
        bus_if.addr       = LED_A;
        bus_if.write_data = 32'h1234ABCD;
        tick();
        check_eq("led_write", 32'(led_out), 32'h0000ABCD);
        bus_if.addr       = 32'hFFFFFC64;
        bus_if.write_data = 32'h0000FFFF;
        tick();
        check_eq("led_badaddr", 32'(led_out), 32'h0000ABCD);
        bus_if.LEDCtrl = 1'b0;

        // Clean change to 00A5: it is accepted on the 7th edge and not before
        bus_if.addr = SW_A;
        switch_in   = 16'h00A5;
        ticks(6);
        rd(SW_A, r);
        check_eq("sw_edge6", 32'(r), 32'h0);
        tick();
        rd(SW_A, r);
        check_eq("sw_edge7", 32'(r), 32'h00A5);
        rd(STAT_A, r);
        check_eq("chg_set", 32'(r), 32'h1);
        bus_if.addr = SW_A;
        tick();
        rd(STAT_A, r);
        tick();
        rd(STAT_A, r);
        check_eq("chg_clear", 32'(r), 32'h0);
        bus_if.addr = SW_A;

        // A 3-clock bounce on bit 0 must be rejected
        switch_in = 16'h00A4;
        ticks(3);
        switch_in = 16'h00A5;
        ticks(12);
        rd(SW_A, r);
        check_eq("bounce_sw", 32'(r), 32'h00A5);
        rd(STAT_A, r);
        check_eq("bounce_chg", 32'(r), 32'h0);
        bus_if.addr = SW_A;

        // Set chg, then apply the status clear on the same edge as the next change
        switch_in = 16'h0000;
        ticks(7);
        rd(STAT_A, r);
        check_eq("chg_set2", 32'(r), 32'h1);
        bus_if.addr = SW_A;
        ticks(5);
        switch_in = 16'h00FF;
        ticks(6);
        bus_if.addr = STAT_A;
        tick();
        rd(STAT_A, r);
        check_eq("set_wins", 32'(r), 32'h1);
        tick();
        rd(STAT_A, r);
        check_eq("chg_clear2", 32'(r), 32'h0);
        rd(SW_A, r);
        check_eq("sw_00ff", 32'(r), 32'h00FF);

        // Reset mid-debounce with the LEDs at FFFF
        bus_if.LEDCtrl    = 1'b1;
        bus_if.addr       = LED_A;
        bus_if.write_data = 32'h0000FFFF;
        tick();
        bus_if.LEDCtrl = 1'b0;
        check_eq("led_ffff", 32'(led_out), 32'h0000FFFF);
        bus_if.addr = SW_A;
        switch_in   = 16'h003C;
        ticks(4);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_led", 32'(led_out), 32'h0);
        check_eq("async_rdata", 32'(bus_if.io_rdata), 32'h0);
        #1 rst_n = 1'b1;
        ticks(6);
        rd(SW_A, r);
        check_eq("post_rst_e6", 32'(r), 32'h0);
        tick();
        rd(SW_A, r);
        check_eq("post_rst_e7", 32'(r), 32'h003C);

        // LED readback, whose result depends on the build option
        bus_if.LEDCtrl    = 1'b1;
        bus_if.addr       = LED_A;
        bus_if.write_data = 32'hFFFF5A5A;
        bus_if.SwitchCtrl = 1'b0;
        tick();
        bus_if.LEDCtrl = 1'b0;
        check_eq("led_5a5a", 32'(led_out), 32'h00005A5A);
        rd(SW_A, r);
        check_eq("sw_read", 32'(r), 32'h003C);
`ifdef IO_LED_READBACK_EN
        rb_exp = 16'h5A5A;
`else
        rb_exp = 16'h0000;
`endif
        rd(LED_A, r);
        check_eq("led_readback", 32'(r), 32'(rb_exp));
        rd(32'hFFFFFC64, r);
        check_eq("rd_other", 32'(r), 32'h0);
        bus_if.SwitchCtrl = 1'b0;
        rd(SW_A, r);
        bus_if.SwitchCtrl = 1'b0;
        #1;
        check_eq("no_strobe", 32'(bus_if.io_rdata), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
